memory_stage_ctrl: RTL

Parametrised memory (M) stage for the 5-stage processor. It replaces the single-cycle, combinational memory stage.
- Drives the data-memory port for lw/sw with a configurable number of wait states, holding the rest of the pipeline with a stall signal until the access completes.
- Flags out-of-range addresses and counts stall cycles for profiling.
- With WAIT_STATES=0 it behaves exactly as the legacy single-cycle stage.

---
 rtl/memory_stage_if.sv | 33 +++
 rtl/memory_stage_ctrl.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/memory_stage_if.sv
// Bundle of X/M-latch inputs, data-memory port and M-stage outputs.
// The slave side is the memory stage itself; the master side is the
// surrounding pipeline plus the data memory.
interface memory_stage_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 12,
  parameter int CNT_WIDTH  = 16
);
  logic [31:0]           instr_xm;
  logic [DATA_WIDTH-1:0] in_dataO;
  logic [DATA_WIDTH-1:0] in_dataB;
  logic [DATA_WIDTH-1:0] q_dmem;
  logic [ADDR_WIDTH-1:0] address_dmem;
  logic [DATA_WIDTH-1:0] d_dmem;
  logic                  dmem_we;
  logic [DATA_WIDTH-1:0] out_dataO;
  logic [DATA_WIDTH-1:0] out_dataD;
  logic                  stall;
  logic                  addr_fault;
  logic [CNT_WIDTH-1:0]  stall_count;

  modport master (
    output instr_xm, in_dataO, in_dataB, q_dmem,
    input  address_dmem, d_dmem, dmem_we, out_dataO, out_dataD,
           stall, addr_fault, stall_count
  );

  modport slave (
    input  instr_xm, in_dataO, in_dataB, q_dmem,
    output address_dmem, d_dmem, dmem_we, out_dataO, out_dataD,
           stall, addr_fault, stall_count
  );
endinterface

// File: rtl/memory_stage_ctrl.sv
// Memory (M) stage controller: drives the data-memory port for lw/sw with
// WAIT_STATES extra cycles per access, stalling upstream latches until the
// access completes. Flags out-of-range addresses (sticky) and counts stall
// cycles with a saturating counter. WAIT_STATES=0 is the legacy
// single-cycle combinational stage.
module memory_stage_ctrl #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 12,
  parameter int WAIT_STATES = 1,
  parameter int CNT_WIDTH   = 16
) (
  input logic            clock,
  input logic            reset,
  memory_stage_if.slave  bus
);

  localparam logic [4:0] OP_LW = 5'b01000;
  localparam logic [4:0] OP_SW = 5'b00111;

  // Wait-state counter reload: the access cycle itself is cycle 0, so the
  // ACCESS state needs N-1 further stalled cycles before completion.
  localparam logic [3:0] WS_RELOAD = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {
    S_IDLE   = 1'b0,
    S_ACCESS = 1'b1
  } state_e;

  state_e                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  op_sw_q, op_sw_d;
  logic                  op_lw_q, op_lw_d;
  logic                  fault_q;
  logic [CNT_WIDTH-1:0]  stall_cnt_q;

  logic [4:0]            opcode_s;
  logic                  is_lw_s;
  logic                  is_sw_s;
  logic                  is_mem_s;
  logic                  in_range_s;
  logic                  stall_s;
  logic                  we_s;
  logic                  fault_hit_s;
  logic [ADDR_WIDTH-1:0] addr_s;
  logic [DATA_WIDTH-1:0] wdata_s;
  logic [DATA_WIDTH-1:0] rdata_s;
  logic                  unused_instr_bits_s;

  assign opcode_s            = bus.instr_xm[31:27];
  assign unused_instr_bits_s = ^bus.instr_xm[26:0];
  assign is_lw_s             = (opcode_s == OP_LW);
  assign is_sw_s             = (opcode_s == OP_SW);
  assign is_mem_s            = is_lw_s | is_sw_s;
  assign in_range_s          = (bus.in_dataO[DATA_WIDTH-1:ADDR_WIDTH] == {(DATA_WIDTH-ADDR_WIDTH){1'b0}});

  // Next-state, latch-update and memory-port decode for the access FSM.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    data_d      = data_q;
    op_sw_d     = op_sw_q;
    op_lw_d     = op_lw_q;
    stall_s     = 1'b0;
    we_s        = 1'b0;
    fault_hit_s = 1'b0;
    addr_s      = bus.in_dataO[ADDR_WIDTH-1:0];
    wdata_s     = bus.in_dataB;
    rdata_s     = {DATA_WIDTH{1'b0}};
    case (state_q)
      S_IDLE: begin
        if (is_mem_s && !in_range_s) begin
          // Out-of-range access retires at once without touching memory.
          fault_hit_s = 1'b1;
        end else if (is_mem_s && (WAIT_STATES == 0)) begin
          we_s    = is_sw_s;
          rdata_s = is_lw_s ? bus.q_dmem : {DATA_WIDTH{1'b0}};
        end else if (is_mem_s) begin
          // Access cycle 0: present the live address/data and capture them,
          // because upstream latches are frozen but not trusted afterwards.
          stall_s = 1'b1;
          addr_d  = bus.in_dataO[ADDR_WIDTH-1:0];
          data_d  = bus.in_dataB;
          op_sw_d = is_sw_s;
          op_lw_d = is_lw_s;
          cnt_d   = WS_RELOAD;
          state_d = S_ACCESS;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ACCESS: begin
        addr_s  = addr_q;
        wdata_s = data_q;
        if (cnt_q != 4'd0) begin
          stall_s = 1'b1;
          cnt_d   = cnt_q - 4'd1;
        end else begin
          // Completion cycle: the pipeline advances at this edge.
          we_s    = op_sw_q;
          rdata_s = op_lw_q ? bus.q_dmem : {DATA_WIDTH{1'b0}};
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Reset gates stall and write enable combinationally so an aborted
  // access can neither hold the pipeline nor write memory.
  assign bus.stall        = stall_s & ~reset;
  assign bus.dmem_we      = we_s & ~reset;
  assign bus.address_dmem = addr_s;
  assign bus.d_dmem       = wdata_s;
  assign bus.out_dataO    = bus.in_dataO;
  assign bus.out_dataD    = rdata_s;
  assign bus.addr_fault   = fault_q;
  assign bus.stall_count  = stall_cnt_q;

  // FSM state, wait counter and captured access registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= {ADDR_WIDTH{1'b0}};
      data_q  <= {DATA_WIDTH{1'b0}};
      op_sw_q <= 1'b0;
      op_lw_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      op_sw_q <= op_sw_d;
      op_lw_q <= op_lw_d;
    end
  end

  // Sticky out-of-range flag and saturating stall-cycle counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      fault_q     <= 1'b0;
      stall_cnt_q <= {CNT_WIDTH{1'b0}};
    end else begin
      fault_q <= fault_q | fault_hit_s;
      if (stall_s && (stall_cnt_q != CNT_MAX)) begin
        stall_cnt_q <= stall_cnt_q + CNT_ONE;
      end else begin
        stall_cnt_q <= stall_cnt_q;
      end
    end
  end

endmodule
